rl_lj_force_accumulator: RTL and testbench

//  Downstream of the 1st-order LJ evaluation pipeline. Sums the per-pair FP32 forces for
//  one reference particle into a single force vector. A pipelined FP adder plus interleaved

---
 rtl/rl_lj_force_accumulator.sv | 187 ++++++++++++++++++
 tb/tb_rl_lj_force_accumulator.sv | 130 +++++++++++++
 2 files changed

// File: rtl/rl_lj_force_accumulator.sv
// rl_lj_force_accumulator: sums per-pair FP32 LJ forces of one reference particle into one force vector
// Ports: clk, rst (async, active-high); force_valid/force_last/force_x/y/z in, in_ready out;
//        acc_valid/acc_x/y/z/acc_pair_count out (pulse at end of group);
//        neg_valid/neg_x/y/z out (negated pair, only with macro ACC_NEWTON3_EN, else tied to 0).
// One adder per axis (latency ADDER_LATENCY) feeds ADDER_LATENCY interleaved partial-sum lanes;
// a DRAIN/REDUCE FSM folds the lanes into lane 0 and emits the total.
module rl_lj_force_accumulator #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDER_LATENCY = 3,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   force_valid,
    input  logic                   force_last,
    input  logic [DATA_WIDTH-1:0]  force_x,
    input  logic [DATA_WIDTH-1:0]  force_y,
    input  logic [DATA_WIDTH-1:0]  force_z,
    output logic                   in_ready,
    output logic                   acc_valid,
    output logic [DATA_WIDTH-1:0]  acc_x,
    output logic [DATA_WIDTH-1:0]  acc_y,
    output logic [DATA_WIDTH-1:0]  acc_z,
    output logic [COUNT_WIDTH-1:0] acc_pair_count,
    output logic                   neg_valid,
    output logic [DATA_WIDTH-1:0]  neg_x,
    output logic [DATA_WIDTH-1:0]  neg_y,
    output logic [DATA_WIDTH-1:0]  neg_z
);
    localparam int L = ADDER_LATENCY;
    localparam int PW = L > 1 ? $clog2(L) : 1;
    localparam logic [PW-1:0] LAST = PW'(L - 1);
    typedef enum logic [1:0] {ACCUM, DRAIN, REDUCE, OUT} state_t;
    state_t state, nxt;
    logic [DATA_WIDTH-1:0] fin [3], lane [3][L], pd [3][L], op_a [3], op_b [3], sum [3], tot [3], acc_r [3];
    logic pv [L];
    logic [PW-1:0] pi [L];
    logic [PW-1:0] ptr, ph, rk, issue_idx;
    logic [COUNT_WIDTH-1:0] cnt, cnt_r;
    logic accept, issue, fwd_hit, fwd0;
    // FP32 add, round-to-nearest-even; denormal inputs/results flush to zero, NaN/Inf propagate
    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b;
        logic [7:0] d;
        logic [26:0] ma, mb;
        logic [27:0] s;
        logic [24:0] r;
        logic signed [9:0] e;
        a = x[30:0] >= y[30:0] ? x : y;
        b = x[30:0] >= y[30:0] ? y : x;
        if (a[30:23] == 8'hff)
            return ((|a[22:0]) || (b[30:23] == 8'hff && a[31] != b[31])) ? 32'h7fc00000 : a;
        if (a[30:23] == 8'h00)
            return {a[31] & b[31], 31'b0};
        if (b[30:23] == 8'h00)
            return a;
        d = a[30:23] - b[30:23];
        ma = {1'b1, a[22:0], 3'b0};
        mb = {1'b1, b[22:0], 3'b0};
        mb = d > 8'd26 ? 27'd1 : (mb >> d) | {26'b0, |(mb & ((27'd1 << d) - 27'd1))};
        s = a[31] == b[31] ? {1'b0, ma} + {1'b0, mb} : {1'b0, ma} - {1'b0, mb};
        if (s == 28'd0)
            return 32'h0;
        e = signed'({2'b0, a[30:23]});
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'sd1;
        end
        for (int i = 0; i < 26; i++)
            if (!s[26]) begin
                s = s << 1;
                e = e - 10'sd1;
            end
        if (e <= 10'sd0)
            return {a[31], 31'b0};
        r = {1'b0, s[26:3]} + {24'b0, s[2] & (s[3] | s[1] | s[0])};
        if (r[24]) begin
            r = r >> 1;
            e = e + 10'sd1;
        end
        if (e >= 10'sd255)
            return {a[31], 8'hff, 23'b0};
        return {a[31], e[7:0], r[22:0]};
    endfunction
    assign fin = '{force_x, force_y, force_z};
    assign in_ready = state == ACCUM;
    assign accept = force_valid & in_ready;
    assign acc_valid = state == OUT;
    // reduction folds lane[k] into lane 0, one add per L cycles
    assign issue = state == ACCUM ? accept : (state == REDUCE && ph == '0);
    assign issue_idx = state == REDUCE ? '0 : ptr;
    // a lane reissued exactly L cycles later reads the result retiring that same cycle
    assign fwd_hit = pv[L-1] && pi[L-1] == issue_idx;
    assign fwd0 = pv[L-1] && pi[L-1] == '0;
    always_comb begin
        for (int a = 0; a < 3; a++) begin
            op_a[a] = fwd_hit ? pd[a][L-1] : lane[a][issue_idx];
            op_b[a] = state == REDUCE ? lane[a][rk] : fin[a];
            sum[a] = fp_add(op_a[a], op_b[a]);
            tot[a] = fwd0 ? pd[a][L-1] : lane[a][0];
        end
    end
    assign acc_x = acc_valid ? tot[0] : acc_r[0];
    assign acc_y = acc_valid ? tot[1] : acc_r[1];
    assign acc_z = acc_valid ? tot[2] : acc_r[2];
    assign acc_pair_count = acc_valid ? cnt : cnt_r;
    always_comb
        nxt = state == ACCUM  ? (accept && force_last ? DRAIN : ACCUM) :
              state == DRAIN  ? (ph == LAST ? (L == 1 ? OUT : REDUCE) : DRAIN) :
              state == REDUCE ? (ph == LAST && rk == LAST ? OUT : REDUCE) : ACCUM;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ACCUM;
        else     state <= nxt;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ptr <= '0;
            ph <= '0;
            rk <= PW'(1);
            cnt <= '0;
            cnt_r <= '0;
            for (int i = 0; i < L; i++) begin
                pv[i] <= 1'b0;
                pi[i] <= '0;
            end
            for (int a = 0; a < 3; a++) begin
                acc_r[a] <= '0;
                for (int i = 0; i < L; i++) begin
                    lane[a][i] <= '0;
                    pd[a][i] <= '0;
                end
            end
        end else begin
            pv[0] <= issue;
            pi[0] <= issue_idx;
            for (int i = 1; i < L; i++) begin
                pv[i] <= pv[i-1];
                pi[i] <= pi[i-1];
            end
            for (int a = 0; a < 3; a++) begin
                pd[a][0] <= sum[a];
                for (int i = 1; i < L; i++)
                    pd[a][i] <= pd[a][i-1];
            end
            ph <= (state == ACCUM || ph == LAST) ? '0 : ph + 1'b1;
            rk <= state != REDUCE ? PW'(1) : (ph == LAST ? rk + 1'b1 : rk);
            if (state == OUT) begin
                ptr <= '0;
                cnt <= '0;
                cnt_r <= cnt;
                for (int a = 0; a < 3; a++) begin
                    acc_r[a] <= tot[a];
                    for (int i = 0; i < L; i++)
                        lane[a][i] <= '0;
                end
            end else begin
                if (pv[L-1])
                    for (int a = 0; a < 3; a++)
                        lane[a][pi[L-1]] <= pd[a][L-1];
                if (accept) begin
                    ptr <= ptr == LAST ? '0 : ptr + 1'b1;
                    cnt <= cnt + COUNT_WIDTH'(cnt != '1);
                end
            end
        end
`ifdef ACC_NEWTON3_EN
    localparam logic [DATA_WIDTH-1:0] SIGN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            neg_valid <= 1'b0;
            neg_x <= '0;
            neg_y <= '0;
            neg_z <= '0;
        end else begin
            neg_valid <= accept;
            if (accept) begin
                neg_x <= force_x ^ SIGN;
                neg_y <= force_y ^ SIGN;
                neg_z <= force_z ^ SIGN;
            end
        end
`else
    assign neg_valid = 1'b0;
    assign neg_x = '0;
    assign neg_y = '0;
    assign neg_z = '0;
`endif
endmodule

// File: tb/tb_rl_lj_force_accumulator.sv
// tb_rl_lj_force_accumulator: directed self-checking bench for rl_lj_force_accumulator (L=3)
module tb_rl_lj_force_accumulator;
    logic clk = 1'b0, rst = 1'b1, force_valid = 1'b0, force_last = 1'b0;
    logic [31:0] force_x = '0, force_y = '0, force_z = '0;
    logic in_ready, acc_valid, neg_valid;
    logic [31:0] acc_x, acc_y, acc_z, neg_x, neg_y, neg_z;
    logic [15:0] acc_pair_count;
    int checks = 0, errors = 0;
    logic seen;
    rl_lj_force_accumulator dut (
        .clk(clk), .rst(rst), .force_valid(force_valid), .force_last(force_last),
        .force_x(force_x), .force_y(force_y), .force_z(force_z), .in_ready(in_ready),
        .acc_valid(acc_valid), .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z),
        .acc_pair_count(acc_pair_count), .neg_valid(neg_valid),
        .neg_x(neg_x), .neg_y(neg_y), .neg_z(neg_z)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z, input logic last);
        force_valid = 1'b1;
        force_last = last;
        force_x = x;
        force_y = y;
        force_z = z;
        step;
        force_valid = 1'b0;
        force_last = 1'b0;
    endtask
    task automatic wait_acc(input string tag, input logic [31:0] ex, input logic [31:0] ey,
                            input logic [31:0] ez, input logic [15:0] ec);
        int n = 1;
        logic busy = 1'b1;
        while (!acc_valid && n < 40) begin
            busy &= !in_ready;
            step;
            n++;
        end
        busy &= !in_ready;
        chk({tag, "_latency"}, n, 10);
        chk({tag, "_busy"}, {31'b0, busy}, 1);
        chk({tag, "_x"}, acc_x, ex);
        chk({tag, "_y"}, acc_y, ey);
        chk({tag, "_z"}, acc_z, ez);
        chk({tag, "_count"}, {16'b0, acc_pair_count}, {16'b0, ec});
        step;
        chk({tag, "_ready_after"}, {31'b0, in_ready}, 1);
        chk({tag, "_pulse_end"}, {31'b0, acc_valid}, 0);
        chk({tag, "_hold_x"}, acc_x, ex);
    endtask
    initial begin
        step;
        step;
        chk("rst_ready", {31'b0, in_ready}, 1);
        chk("rst_valid", {31'b0, acc_valid}, 0);
        chk("rst_x", acc_x, 0);
        chk("rst_count", {16'b0, acc_pair_count}, 0);
        rst = 1'b0;
        step;
        send(32'h3F800000, 32'h40000000, 32'hBF800000, 1'b1);
`ifdef ACC_NEWTON3_EN
        chk("n3_valid", {31'b0, neg_valid}, 1);
        chk("n3_x", neg_x, 32'hBF800000);
        chk("n3_z", neg_z, 32'h3F800000);
`else
        chk("n3_off_valid", {31'b0, neg_valid}, 0);
        chk("n3_off_x", neg_x, 0);
`endif
        wait_acc("single", 32'h3F800000, 32'h40000000, 32'hBF800000, 16'd1);
        send(32'h40000000, 32'h0, 32'h0, 1'b0);
        send(32'h40000000, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'b0, acc_valid}, 0);
        chk("midrst_x", acc_x, 0);
        chk("midrst_count", {16'b0, acc_pair_count}, 0);
        step;
        rst = 1'b0;
        chk("midrst_ready", {31'b0, in_ready}, 1);
        step;
        send(32'h3F800000, 32'h0, 32'h0, 1'b1);
        wait_acc("after_rst", 32'h3F800000, 32'h0, 32'h0, 16'd1);
        send(32'h3F800000, 32'hBF800000, 32'h0, 1'b0);
        send(32'h40000000, 32'hBF800000, 32'h0, 1'b0);
        send(32'h40400000, 32'hBF800000, 32'h0, 1'b0);
        send(32'h40800000, 32'hBF800000, 32'h0, 1'b1);
        wait_acc("four", 32'h41200000, 32'hC0800000, 32'h0, 16'd4);
        for (int i = 0; i < 6; i++) begin
            send(32'h40000000, 32'h0, 32'hC0000000, i == 5);
            if (i < 5) begin
                step;
                step;
            end
        end
        wait_acc("six_gap", 32'h41400000, 32'h0, 32'hC1400000, 16'd6);
        send(32'h40000000, 32'h0, 32'h0, 1'b1);
        force_valid = 1'b1;
        force_x = 32'h40800000;
        wait_acc("held", 32'h40000000, 32'h0, 32'h0, 16'd1);
        force_valid = 1'b0;
        send(32'h3F800000, 32'h0, 32'h0, 1'b1);
        wait_acc("no_carry", 32'h3F800000, 32'h0, 32'h0, 16'd1);
        send(32'h40400000, 32'h0, 32'h0, 1'b1);
        repeat (5) step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            seen |= acc_valid;
            step;
        end
        chk("reduce_rst_novalid", {31'b0, seen}, 0);
        chk("reduce_rst_ready", {31'b0, in_ready}, 1);
        send(32'h40000000, 32'h40400000, 32'h0, 1'b0);
        send(32'h40000000, 32'hBF800000, 32'h0, 1'b1);
        wait_acc("post_reduce_rst", 32'h40800000, 32'h40000000, 32'h0, 16'd2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
